// File: rtl/instruction_to_line.sv
// RV32I disassembler: latches one instruction word and streams its assembly text
// as ASCII characters over a valid/ready handshake, ending each line with 0x0A.
module instruction_to_line #(
    parameter int CHAR_PER_LINE = 64
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             start,
    input  logic [31:0]                      instruction,
    output logic [7:0]                       outgoing_character,
    output logic                             char_valid,
    input  logic                             char_ready,
    output logic [$clog2(CHAR_PER_LINE)-1:0] char_count,
    output logic                             done_flag,
    output logic                             error_flag,
    output logic                             busy_flag
);

    // IDLE wait start | DECODE classify | CONVERT binary->BCD | EMIT stream | DONE/ERROR pulse
    localparam logic [2:0] S_IDLE = 3'd0, S_DECODE = 3'd1, S_CONVERT = 3'd2,
                           S_EMIT = 3'd3, S_DONE = 3'd4, S_ERROR = 3'd5;

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_LW = 3'd2,
                           FMT_SW = 3'd3, FMT_B = 3'd4, FMT_U = 3'd5;

    localparam logic [3:0] F_MNEM = 4'd0, F_SP = 4'd1, F_RD = 4'd2, F_RS1 = 4'd3,
                           F_RS2 = 4'd4, F_SEP = 4'd5, F_IMM = 4'd6, F_LPAR = 4'd7,
                           F_RPAR = 4'd8, F_NL = 4'd9;

    // Field sequences, first field in the least significant nibble.
    localparam logic [35:0] SEQ_R  = {F_NL, F_NL, F_RS2, F_SEP, F_RS1, F_SEP, F_RD, F_SP, F_MNEM};
    localparam logic [35:0] SEQ_I  = {F_NL, F_NL, F_IMM, F_SEP, F_RS1, F_SEP, F_RD, F_SP, F_MNEM};
    localparam logic [35:0] SEQ_LW = {F_NL, F_RPAR, F_RS1, F_LPAR, F_IMM, F_SEP, F_RD, F_SP, F_MNEM};
    localparam logic [35:0] SEQ_SW = {F_NL, F_RPAR, F_RS1, F_LPAR, F_IMM, F_SEP, F_RS2, F_SP, F_MNEM};
    localparam logic [35:0] SEQ_B  = {F_NL, F_NL, F_IMM, F_SEP, F_RS2, F_SEP, F_RS1, F_SP, F_MNEM};
    localparam logic [35:0] SEQ_U  = {F_NL, F_NL, F_NL, F_NL, F_IMM, F_SEP, F_RD, F_SP, F_MNEM};

    logic [2:0]  state;
    logic [31:0] ins_q;
    logic [27:0] bcd_q;
    logic [20:0] bin_q;
    logic [4:0]  cnv_cnt;
    logic [3:0]  fld_idx;
    logic [2:0]  sub_idx;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3, fmt, mlen;
    logic        ok, neg;
    logic [39:0] mnem;
    logic [21:0] imm;
    logic [20:0] mag;

    always_comb begin
        opcode = ins_q[6:0];
        funct3 = ins_q[14:12];
        funct7 = ins_q[31:25];
        ok     = 1'b0;
        fmt    = FMT_R;
        mnem   = "     ";
        imm    = '0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    ok = 1'b1;
                    case (funct3)
                        3'd0:    mnem = "add  ";
                        3'd1:    mnem = "sll  ";
                        3'd2:    mnem = "slt  ";
                        3'd3:    mnem = "sltu ";
                        3'd4:    mnem = "xor  ";
                        3'd5:    mnem = "srl  ";
                        3'd6:    mnem = "or   ";
                        default: mnem = "and  ";
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    ok   = 1'b1;
                    mnem = "sub  ";
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    ok   = 1'b1;
                    mnem = "sra  ";
                end
            end
            7'b0010011: begin
                fmt = FMT_I;
                ok  = 1'b1;
                imm = {{10{ins_q[31]}}, ins_q[31:20]};
                case (funct3)
                    3'd0: mnem = "addi ";
                    3'd2: mnem = "slti ";
                    3'd3: mnem = "sltiu";
                    3'd4: mnem = "xori ";
                    3'd6: mnem = "ori  ";
                    3'd7: mnem = "andi ";
                    3'd1: begin
                        mnem = "slli ";
                        imm  = {17'd0, ins_q[24:20]};
                        ok   = (funct7 == 7'b0000000);
                    end
                    default: begin
                        imm = {17'd0, ins_q[24:20]};
                        if (funct7 == 7'b0000000)      mnem = "srli ";
                        else if (funct7 == 7'b0100000) mnem = "srai ";
                        else                           ok   = 1'b0;
                    end
                endcase
            end
            7'b0000011: begin
                fmt  = FMT_LW;
                mnem = "lw   ";
                imm  = {{10{ins_q[31]}}, ins_q[31:20]};
                ok   = (funct3 == 3'b010);
            end
            7'b0100011: begin
                fmt  = FMT_SW;
                mnem = "sw   ";
                imm  = {{10{ins_q[31]}}, ins_q[31:25], ins_q[11:7]};
                ok   = (funct3 == 3'b010);
            end
            7'b1100011: begin
                fmt = FMT_B;
                ok  = 1'b1;
                imm = {{9{ins_q[31]}}, ins_q[31], ins_q[7], ins_q[30:25], ins_q[11:8], 1'b0};
                case (funct3)
                    3'd0:    mnem = "beq  ";
                    3'd1:    mnem = "bne  ";
                    3'd4:    mnem = "blt  ";
                    3'd5:    mnem = "bge  ";
                    3'd6:    mnem = "bltu ";
                    3'd7:    mnem = "bgeu ";
                    default: ok   = 1'b0;
                endcase
            end
            7'b0110111: begin
                fmt  = FMT_U;
                ok   = 1'b1;
                mnem = "lui  ";
                imm  = {2'b00, ins_q[31:12]};
            end
            7'b1101111: begin
                fmt  = FMT_U;
                ok   = 1'b1;
                mnem = "jal  ";
                imm  = {ins_q[31], ins_q[31], ins_q[19:12], ins_q[20], ins_q[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        mlen = 3'd0;
        for (int k = 0; k < 5; k++)
            if (mnem[39-8*k -: 8] != 8'h20) mlen = 3'(k + 1);
    end

    assign neg = imm[21];
    assign mag = neg ? 21'(-imm) : imm[20:0];

    logic [27:0] bcd_adj;
    logic [2:0]  ndig;

    always_comb begin
        bcd_adj = bcd_q;
        ndig    = 3'd1;
        for (int d = 0; d < 7; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            if (bcd_q[4*d +: 4] != 4'd0) ndig = 3'(d + 1);
        end
    end

    logic [35:0] seq;
    logic [3:0]  fld, flen;
    logic [4:0]  reg_sel, r_units;
    logic [1:0]  r_tens;
    logic [2:0]  p, di;
    logic [3:0]  dig;
    logic [7:0]  mch, ch;
    logic        last_char;

    always_comb begin
        case (fmt)
            FMT_I:   seq = SEQ_I;
            FMT_LW:  seq = SEQ_LW;
            FMT_SW:  seq = SEQ_SW;
            FMT_B:   seq = SEQ_B;
            FMT_U:   seq = SEQ_U;
            default: seq = SEQ_R;
        endcase
        fld = 4'(seq >> {fld_idx, 2'b00});

        case (fld)
            F_RS1:   reg_sel = ins_q[19:15];
            F_RS2:   reg_sel = ins_q[24:20];
            default: reg_sel = ins_q[11:7];
        endcase
        r_tens  = (reg_sel >= 5'd30) ? 2'd3 : (reg_sel >= 5'd20) ? 2'd2 :
                  (reg_sel >= 5'd10) ? 2'd1 : 2'd0;
        r_units = reg_sel - 5'(r_tens * 4'd10);

        mch = 8'(mnem >> {(3'd4 - sub_idx), 3'b000});
        p   = sub_idx - {2'b00, neg};
        di  = ndig - 3'd1 - p;
        dig = 4'(bcd_q >> {di, 2'b00});

        flen = 4'd1;
        ch   = 8'h0A;
        case (fld)
            F_MNEM: begin
                flen = {1'b0, mlen};
                ch   = mch;
            end
            F_SP: ch = 8'h20;
            F_RD, F_RS1, F_RS2: begin
                flen = (reg_sel >= 5'd10) ? 4'd3 : 4'd2;
                if (sub_idx == 3'd0)                             ch = 8'h78;
                else if (sub_idx == 3'd1 && reg_sel >= 5'd10)    ch = 8'h30 + {6'd0, r_tens};
                else                                             ch = 8'h30 + {3'd0, r_units};
            end
            F_SEP: begin
                flen = 4'd2;
                ch   = (sub_idx == 3'd0) ? 8'h2C : 8'h20;
            end
            F_IMM: begin
                flen = {1'b0, ndig} + {3'd0, neg};
                ch   = (neg && sub_idx == 3'd0) ? 8'h2D : 8'h30 + {4'd0, dig};
            end
            F_LPAR:  ch = 8'h28;
            F_RPAR:  ch = 8'h29;
            default: ch = 8'h0A;
        endcase
        last_char = ({1'b0, sub_idx} == flen - 4'd1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= S_IDLE;
            ins_q      <= '0;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnv_cnt    <= '0;
            fld_idx    <= '0;
            sub_idx    <= '0;
            char_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    ins_q      <= instruction;
                    char_count <= '0;
                    state      <= S_DECODE;
                end
                S_DECODE: begin
                    bin_q   <= mag;
                    bcd_q   <= '0;
                    cnv_cnt <= 5'd20;
                    fld_idx <= '0;
                    sub_idx <= '0;
                    if (!ok)               state <= S_ERROR;
                    else if (fmt == FMT_R) state <= S_EMIT;
                    else                   state <= S_CONVERT;
                end
                S_CONVERT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    if (cnv_cnt == 5'd0) state   <= S_EMIT;
                    else                 cnv_cnt <= cnv_cnt - 1'b1;
                end
                S_EMIT: if (char_ready) begin
                    char_count <= char_count + 1'b1;
                    if (last_char) begin
                        sub_idx <= '0;
                        fld_idx <= fld_idx + 1'b1;
                        if (fld == F_NL) state <= S_DONE;
                    end else begin
                        sub_idx <= sub_idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign char_valid         = (state == S_EMIT);
    assign outgoing_character = char_valid ? ch : 8'h00;
    assign done_flag          = (state == S_DONE);
    assign error_flag         = (state == S_ERROR);
    assign busy_flag          = (state != S_IDLE);

endmodule

// File: doc/instruction_to_line.md
# instruction_to_line

Disassembler line emitter: accepts one 32-bit RV32I instruction word and streams its assembly text as ASCII characters, one per handshake, terminated by newline. It is the inverse of the assembler's character-to-instruction front end and shares its text format, so emitted lines round-trip through the assembler unchanged. It sits between instruction memory/debug readout and a UART or character buffer.

## Interface
- CHAR_PER_LINE, 64: maximum line length; sizes `char_count`. Every supported line is shorter than this.
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- start  in  1  begin disassembly of `instruction`; honoured only in IDLE
- instruction  in  32  instruction word; latched on the accepted `start` edge
- outgoing_character  out  8  ASCII character
- char_valid  out  1  `outgoing_character` is valid
- char_ready  in  1  sink accepts the character; transfer = `char_valid && char_ready` at a rising edge
- char_count  out  $clog2(CHAR_PER_LINE)  characters transferred on the current line
- done_flag  out  1  one-cycle pulse: line complete
- error_flag  out  1  one-cycle pulse: unsupported encoding
- busy_flag  out  1  state != IDLE

## Operation
- Supported set:
  - R-type: add sub sll slt sltu xor srl sra or and.
  - I-ALU: addi slti sltiu xori ori andi slli srli srai.
  - Memory: lw, sw.
  - Branches: beq bne blt bge bltu bgeu.
  - Upper/jump: lui, jal.
  - Anything else, including a bad funct7 on R-type or shifts, is unsupported.
- Line formats: lowercase mnemonic, one space, operands separated by ", ", then 0x0A.
  - R: "add x3, x1, x2" (rd, rs1, rs2).
  - I-ALU: "addi x1, x2, -5". Shifts print shamt unsigned (0..31).
  - lw: "lw x5, 8(x2)". sw: "sw x5, -4(x2)" (rs2, imm(rs1)).
  - Branch: "beq x1, x2, -8" (rs1, rs2, signed byte offset).
  - lui: "lui x1, 74565" (imm[31:12] unsigned). jal: "jal x1, 2048" (rd, signed byte offset).
- Registers print as "x" plus a decimal index 0..31, with no leading zero.
- Immediates print in decimal:
  - '-' prefix only when negative.
  - Leading zeros suppressed; value 0 prints "0".
  - Magnitude is at most 21 bits, so at most 7 digits.
- States:
  - IDLE → DECODE on `start`.
  - DECODE (1 cycle): classify, sign-extend, take the magnitude. Unsupported → ERROR. R-type → EMIT. Otherwise → CONVERT.
  - CONVERT: exactly 21 cycles of double-dabble on the 21-bit magnitude into 7 BCD digits, then → EMIT.
  - EMIT: walks mnemonic, operand, separator and digit fields in order; the final character is 0x0A. After the 0x0A transfer → DONE.
  - DONE (1 cycle, `done_flag`=1) → IDLE.
  - ERROR (1 cycle, `error_flag`=1, no characters emitted) → IDLE.
- `char_count` clears on the accepted `start` and increments on each transfer. After DONE it holds the final line length until the next `start`.
- `start` while busy is ignored; the latched instruction is not disturbed.

## Timing
- Reset values: `char_valid`=0, `outgoing_character`=0x00, `char_count`=0, `done_flag`=0, `error_flag`=0, `busy_flag`=0, state IDLE.
- Reset acts asynchronously at any point. An in-flight line is abandoned and `char_valid` drops immediately.
- Let `start` be sampled at edge N:
  - DECODE occupies N..N+1.
  - R-type: `char_valid` first high after edge N+1.
  - Immediate types: `char_valid` first high after edge N+22.
  - Unsupported: `error_flag` high for the cycle after edge N+1.
- With `char_ready` held high, one character transfers per cycle with no bubbles, including across field boundaries.
- Backpressure: while `char_valid && !char_ready`, `outgoing_character` and `char_valid` hold stable. `char_valid` never drops without a transfer.
- `done_flag` is high for the cycle after the edge that transfers 0x0A. `busy_flag` falls at the end of that cycle.
- `start` may be asserted in the cycle `done_flag` is high. It is ignored there; it is accepted only once IDLE is reached.

## Test plan
- 0x002081B3, ready always high → "add x3, x1, x2\n" (15 chars). First valid at N+2, one char per cycle, `done_flag` after the 15th, `char_count`=15.
- 0xFFB00093 → "addi x1, x0, -5\n". First valid at N+23.
- 0xFE512E23 → "sw x5, -4(x2)\n".
- 0x123450B7 → "lui x1, 74565\n" (7 BCD digits, leading zeros suppressed). 0x00000013 → "addi x0, x0, 0\n".
- Random `char_ready` backpressure on 0x002081B3 → identical character sequence, character held stable while stalled. Extra `start` pulses while busy → no effect.
- 0x00000000 → `error_flag` one-cycle pulse at N+2, zero transfers. Then `rst_in` low mid-line → outputs return to reset values immediately, and the next `start` produces a complete correct line.
